// File: rtl/subtract_pkg.sv
// Shared definitions for the bit-serial subtracter controller.
//   state_t       : controller FSM state encoding (IDLE/RUN/DONE)
//   DEFAULT_WIDTH : default operand/result width in bits
package subtract_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtracter_cell.sv
// One-bit full subtracter built from two half subtracters and an OR.
// Computes d = x - y - bin and the borrow out.
// Ports:
//   x    : minuend bit
//   y    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit  (x ^ y ^ bin)
//   bout : borrow out      ((~x & y) | (~(x ^ y) & bin))
module full_subtracter_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_d1;
  logic w_b1;
  logic w_b2;

  half_subtracter u_hs0 (
    .x  (x),
    .y  (y),
    .d  (w_d1),
    .bo (w_b1)
  );

  half_subtracter u_hs1 (
    .x  (w_d1),
    .y  (bin),
    .d  (d),
    .bo (w_b2)
  );

  assign bout = w_b1 | w_b2;

endmodule

// File: rtl/half_subtracter.sv
// Gate-level half subtracter: d = x - y (one bit), bo = borrow out.
// Ports:
//   x  : minuend bit
//   y  : subtrahend bit
//   d  : difference bit (x ^ y)
//   bo : borrow out (~x & y)
module half_subtracter (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule

// File: rtl/serial_subtract_ctrl.sv
// Bit-serial WIDTH-bit subtracter controller. Reuses one full subtracter
// cell over the word, LSB first, one bit per clock, computing a - b.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : request pulse, sampled only while idle
//   a, b       : minuend / subtrahend, captured on the accepted start
//   busy       : high while bits are being processed
//   done       : one-cycle pulse when diff/borrow_out become valid
//   diff       : result register, a - b modulo 2^WIDTH
//   borrow_out : final borrow, 1 iff a < b unsigned
module serial_subtract_ctrl
  import subtract_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  // Only WIDTH-1 earlier bits are stored: the final bit goes straight from
  // the cell into the result register on the last RUN cycle.
  logic [WIDTH-2:0] r_part;
  logic             r_bflop;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic             w_d;
  logic             w_bout;
  logic             w_last;
  logic [WIDTH-1:0] w_part_next;

  full_subtracter_cell u_cell (
    .x    (r_sa[0]),
    .y    (r_sb[0]),
    .bin  (r_bflop),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_part_next = {w_d, r_part};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_part   <= '0;
      r_bflop  <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_part  <= '0;
            r_bflop <= 1'b0;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_sa    <= r_sa >> 1;
          r_sb    <= r_sb >> 1;
          r_part  <= w_part_next[WIDTH-1:1];
          r_bflop <= w_bout;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_diff   <= w_part_next;
            r_borrow <= w_bout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign diff       = r_diff;
  assign borrow_out = r_borrow;

endmodule
